// File: rtl/ic_fill_unit.sv
// Instruction-cache line-fill controller: one burst read per miss, eight
// 32-bit beats assembled little-endian into a 256-bit line, returned with a one-cycle ack.
module ic_fill_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_miss,
  input  logic [31:0]  ic_miss_addr,
  output logic [255:0] ic_fill_data,
  output logic         ic_miss_ack,
  output logic [31:0]  ic_miss_ack_address,
  output logic         ic_fill_err,
  output logic         mem_rd_req,
  output logic [31:0]  mem_rd_addr,
  input  logic         mem_rd_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_err,
  output logic [1:0]   dbg_state
);

  // Handshakes: mem_rd_req is held with a stable mem_rd_addr until the cycle
  // mem_rd_gnt is high; a beat transfers on any DATA cycle with mem_rvalid high
  // (no back-pressure); ic_miss is a level that only IDLE samples.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic         err_q, err_d;
  logic [255:0] line_q, line_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      err_q   <= 1'b0;
      line_q  <= 256'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (ic_miss) begin
          addr_d  = {ic_miss_addr[31:5], 5'b0};
          cnt_d   = 3'd0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_rd_gnt) state_d = S_DATA;
      end
      S_DATA: begin
        if (mem_rvalid) begin
          // The old line stays visible until each slot is overwritten.
          for (int k = 0; k < 8; k++) begin
            if (cnt_q == 3'(k)) line_d[32*k +: 32] = mem_rdata;
          end
          cnt_d = cnt_q + 3'd1;
          err_d = err_q | mem_err;
          if (cnt_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs come from registers only.
  assign mem_rd_req          = (state_q == S_REQ);
  assign mem_rd_addr         = mem_rd_req ? addr_q : 32'd0;
  assign ic_miss_ack         = (state_q == S_ACK);
  assign ic_fill_err         = ic_miss_ack & err_q;
  assign ic_fill_data        = line_q;
  assign ic_miss_ack_address = addr_q;
  assign dbg_state           = state_q;

endmodule

// File: doc/ic_fill_unit.md
# ic_fill_unit

Instruction-cache line-fill controller, sitting directly upstream of the i_cache in the fetch stage. It accepts a miss from the i_cache and issues one burst read to the memory side, which returns eight 32-bit beats. It assembles the beats into a 256-bit line and returns that line, with its address, to the i_cache as a one-cycle fill acknowledge.

## Interface
- No parameters; line = 256 bits (32 bytes), beat = 32 bits, 8 beats per line.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ic_miss  in  1  level; the i_cache holds it high while a miss is outstanding.
- ic_miss_addr  in  32  byte address of the missing fetch; only valid together with ic_miss.
- ic_fill_data  out  256  assembled line; valid in the ack cycle and held until the next fill starts.
- ic_miss_ack  out  1  one-cycle pulse: line fill complete.
- ic_miss_ack_address  out  32  line-aligned address of the filled line (bits [4:0] = 0); held like ic_fill_data.
- ic_fill_err  out  1  high together with ic_miss_ack if any beat of the fill carried mem_err.
- mem_rd_req  out  1  burst read request; held until granted.
- mem_rd_addr  out  32  line-aligned burst address; stable while mem_rd_req is high.
- mem_rd_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  mem_rdata carries a beat this cycle.
- mem_rdata  in  32  beat data.
- mem_err  in  1  error qualifier for the beat; sampled only with mem_rvalid.

## Operation
- States are IDLE, REQ, DATA and ACK. The state is a registered FSM with a 3-bit beat counter.
- IDLE: if ic_miss = 1, latch {ic_miss_addr[31:5], 5'b0} into the address register, clear the beat counter and the error flag, and go to REQ.
- REQ: mem_rd_req = 1 and mem_rd_addr = the latched address. When mem_rd_gnt = 1, go to DATA.
- DATA: on each cycle with mem_rvalid = 1, write mem_rdata into line bits [32k+31:32k], where k is the beat counter. Then increment k and OR mem_err into the error flag. The beat with k = 7 moves the FSM to ACK. Beats may arrive with gaps; cycles with mem_rvalid = 0 change nothing.
- ACK: ic_miss_ack = 1 for exactly this cycle, and ic_fill_err = the error flag. The FSM then returns to IDLE unconditionally.
- Beats are little-endian: beat 0 = bytes 0-3 of the line = bits [31:0]. Beats arrive in linear order; there is no critical-word-first.
- mem_rvalid is ignored in IDLE, REQ and ACK, and a stray beat must not corrupt the line buffer.
- ic_miss is ignored outside IDLE. A miss address that changes mid-fill has no effect.
- The i_cache must drop ic_miss in the cycle after ic_miss_ack. If ic_miss is still high when the FSM is back in IDLE, it is treated as a new miss and a new fill starts.
- The i_cache locates the fill using ic_miss_ack_address; this block does no tag or index handling.
- Reset mid-fill: the FSM goes to IDLE immediately and asynchronously, and the partial line is discarded. Beats still in flight afterwards are ignored, because they arrive while the FSM is in IDLE.

## Timing
- Reset values: state IDLE, counter 0, ic_fill_data 0, ic_miss_ack_address 0, ic_miss_ack 0, ic_fill_err 0, mem_rd_req 0, mem_rd_addr 0.
- mem_rd_req, mem_rd_addr, ic_miss_ack and ic_fill_err are decoded from registered state only. There is no combinational path from any input to any output.
- mem_rd_req rises in the cycle after ic_miss is sampled in IDLE.
- A grant in REQ cycle t allows the first beat at cycle t+1 at the earliest.
- ic_miss_ack is asserted in the cycle after the beat-7 rvalid.
- Minimum miss-to-ack latency is 10 cycles: miss sampled at cycle 0, request and grant at cycle 1, beats at cycles 2-9, ack at cycle 10.
- Back-to-back fills: after the ACK cycle the FSM spends one cycle in IDLE. The next mem_rd_req therefore rises at ack+2 at the earliest.
- ic_fill_data and ic_miss_ack_address change only in DATA/IDLE-capture cycles. They are never modified during ACK.

## Test plan
- Basic fill: ic_miss=1 with addr 0x0000_0127. Grant immediately, then 8 back-to-back beats 0x11111111..0x88888888. Required: mem_rd_addr = 0x0000_0120, and ic_miss_ack at cycle 10 with ic_miss_ack_address 0x0000_0120. ic_fill_data[31:0] = 0x11111111, ic_fill_data[255:224] = 0x88888888, ic_fill_err = 0.
- Delayed grant and gappy beats: grant after 5 REQ cycles, one idle cycle between each pair of beats. Required: mem_rd_req/addr stay stable until the grant; the line is correct; ack comes exactly one cycle after beat 7.
- Error beat: mem_err=1 on beat 3 only. Required: ic_fill_err=1 with ack, and the line data is still assembled.
- Stray/late traffic: mem_rvalid pulsed in IDLE and REQ with data 0xDEADBEEF. Required: the buffer is unchanged and no beat is counted. Also, change ic_miss_addr mid-fill: the ack address keeps the original line.
- Back-to-back misses: ic_miss is held high through the ack cycle. Required: a second mem_rd_req rises at ack+2, and the previous ic_fill_data is held until the new beat 0 arrives.
- Reset mid-DATA after 4 beats: rst_n low for 1 cycle. Required: all outputs are at their reset values; the remaining 4 beats are ignored; no ack; a subsequent miss fills correctly.
